// File: rtl/alu_share_arbiter_pkg.sv
// rtl/alu_share_arbiter_pkg.sv - shared types and constants for the ALU share arbiter
//
// Purpose: FSM state encoding, ALU op-class constants and the default datapath
// width used by the arbiter and its round-robin helper.
package alu_share_arbiter_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/alu_share_arbiter_rr_arbiter2.sv
// rtl/alu_share_arbiter_rr_arbiter2.sv - two-way round-robin grant selection
//
// Purpose: picks the pointer's requester when it is valid, otherwise the other.
// Ports:
//   valid[1:0]  in   per-requester valid
//   ptr         in   priority pointer (requester index favoured this round)
//   grant[1:0]  out  one-hot grant, zero when no requester is valid
//   grant_idx   out  index of the selected requester (meaningful only if grant != 0)
module rr_arbiter2
  import alu_share_arbiter_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic [1:0] grant,
  output logic       grant_idx
);

  always_comb begin
    grant_idx = valid[ptr] ? ptr : ~ptr;
    grant     = 2'b00;
    if (valid != 2'b00) begin
      grant[grant_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - shares one single-cycle ALU between two requesters
//
// Purpose: accepts ALU requests from two requesters over valid/ready, arbitrates
// round-robin, registers the granted op toward the ALU, captures the result one
// cycle later and returns it on a single response channel tagged with the id.
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   req_valid[1:0] / req_ready request handshake, bit i = requester i
//   reqN_aluop/fun3/fun7/a/b   request op fields and operands per requester
//   alu_aluop/fun3/fun7/a/b    registered op fields and operands to the ALU
//   alu_result, alu_zero       combinational ALU outputs
//   rsp_valid / rsp_ready      response handshake
//   rsp_id, rsp_result, rsp_zero  response payload, held until accepted
//   busy                       high whenever a transaction is in flight
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [1:0]      req0_aluop,
  input  logic [2:0]      req0_fun3,
  input  logic            req0_fun7,
  input  logic [XLEN-1:0] req0_a,
  input  logic [XLEN-1:0] req0_b,
  input  logic [1:0]      req1_aluop,
  input  logic [2:0]      req1_fun3,
  input  logic            req1_fun7,
  input  logic [XLEN-1:0] req1_a,
  input  logic [XLEN-1:0] req1_b,
  output logic [1:0]      alu_aluop,
  output logic [2:0]      alu_fun3,
  output logic            alu_fun7,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_zero,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_id,
  output logic [XLEN-1:0] rsp_result,
  output logic            rsp_zero,
  output logic            busy
);

  arb_state_e state_q, state_d;
  logic       ptr_q;
  logic       id_q;
  logic [1:0] grant;
  logic       grant_idx;
  logic       accept;

  logic [1:0]      sel_aluop;
  logic [2:0]      sel_fun3;
  logic            sel_fun7;
  logic [XLEN-1:0] sel_a;
  logic [XLEN-1:0] sel_b;

  rr_arbiter2 u_rr_arbiter2 (
    .valid     (req_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign accept = (state_q == IDLE) && (req_valid != 2'b00);

  always_comb begin
    sel_aluop = grant_idx ? req1_aluop : req0_aluop;
    sel_fun3  = grant_idx ? req1_fun3  : req0_fun3;
    sel_fun7  = grant_idx ? req1_fun7  : req0_fun7;
    sel_a     = grant_idx ? req1_a     : req0_a;
    sel_b     = grant_idx ? req1_b     : req0_b;
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 2'b00;
    unique case (state_q)
      IDLE: begin
        // Ready is combinational from the arbiter; it is masked while reset
        // is asserted so every output reads zero during reset.
        if (rst_n) begin
          req_ready = grant;
        end
        if (accept) begin
          state_d = EXEC;
        end
      end
      EXEC: state_d = RESP;
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Decoded straight from the state register so both fall the instant reset
  // asserts, even mid-response.
  assign rsp_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);
  assign rsp_id    = id_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= 1'b0;
      id_q       <= 1'b0;
      alu_aluop  <= '0;
      alu_fun3   <= '0;
      alu_fun7   <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        alu_aluop <= sel_aluop;
        alu_fun3  <= sel_fun3;
        alu_fun7  <= sel_fun7;
        alu_a     <= sel_a;
        alu_b     <= sel_b;
        id_q      <= grant_idx;
      end
      if (state_q == EXEC) begin
        rsp_result <= alu_result;
        rsp_zero   <= alu_zero;
      end
      // The requester just served drops to lowest priority, so a waiting
      // requester never sees more than one other transaction ahead of it.
      if ((state_q == RESP) && rsp_ready) begin
        ptr_q <= ~id_q;
      end
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - scoreboard testbench for alu_share_arbiter
module tb_alu_share_arbiter;
  import alu_share_arbiter_pkg::*;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [1:0]      req_valid = 2'b00;
  logic [1:0]      req_ready;
  logic [1:0]      r_aluop [2];
  logic [2:0]      r_fun3 [2];
  logic            r_fun7 [2];
  logic [XLEN-1:0] r_a [2];
  logic [XLEN-1:0] r_b [2];
  logic [1:0]      alu_aluop;
  logic [2:0]      alu_fun3;
  logic            alu_fun7;
  logic [XLEN-1:0] alu_a, alu_b, alu_result;
  logic            alu_zero;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic            rsp_id;
  logic [XLEN-1:0] rsp_result;
  logic            rsp_zero;
  logic            busy;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic            id;
    logic [XLEN-1:0] res;
    logic            z;
  } exp_t;
  exp_t sbq[$];

  initial forever #5 clk = ~clk;

  alu_share_arbiter #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req0_aluop(r_aluop[0]), .req0_fun3(r_fun3[0]), .req0_fun7(r_fun7[0]),
    .req0_a(r_a[0]), .req0_b(r_b[0]),
    .req1_aluop(r_aluop[1]), .req1_fun3(r_fun3[1]), .req1_fun7(r_fun7[1]),
    .req1_a(r_a[1]), .req1_b(r_b[1]),
    .alu_aluop(alu_aluop), .alu_fun3(alu_fun3), .alu_fun7(alu_fun7),
    .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .busy(busy)
  );

  // Reference RV32 ALU; op class 11 gets an arbitrary but distinctive result.
  function automatic logic [XLEN-1:0] alu_ref(logic [1:0] op, logic [2:0] f3, logic f7,
                                              logic [XLEN-1:0] a, logic [XLEN-1:0] b);
    case (op)
      ALUOP_ADD: return a + b;
      ALUOP_SUB: return a - b;
      ALUOP_RTYPE: begin
        case (f3)
          3'b000:  return f7 ? a - b : a + b;
          3'b001:  return a << b[4:0];
          3'b010:  return {31'b0, $signed(a) < $signed(b)};
          3'b011:  return {31'b0, a < b};
          3'b100:  return a ^ b;
          3'b101:  return f7 ? XLEN'($signed(a) >>> b[4:0]) : a >> b[4:0];
          3'b110:  return a | b;
          default: return a & b;
        endcase
      end
      default: return a ^ ~b;
    endcase
  endfunction

  assign alu_result = alu_ref(alu_aluop, alu_fun3, alu_fun7, alu_a, alu_b);
  assign alu_zero   = (alu_result == '0);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: bound expired, got no event, expected one", name);
  endtask

  // Monitor / scoreboard: models the transaction-level behaviour (one op in
  // flight, response two cycles after accept, round-robin pointer handoff).
  initial begin
    int   cyc;
    int   acc_cyc;
    bit   outst;
    bit   o;
    bit   mptr;
    bit   hold;
    logic hid;
    logic hz;
    logic [XLEN-1:0] hres;
    logic gi;
    logic [1:0] eg;
    exp_t e;
    cyc = 0; acc_cyc = 0; outst = 0; mptr = 0; hold = 0;
    hid = 0; hz = 0; hres = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        sbq.delete();
        outst = 0;
        mptr  = 0;
        hold  = 0;
        continue;
      end
      o = outst;
      check("rsp_valid_timing", rsp_valid, o && (cyc - acc_cyc >= 2));
      check("busy", busy, o);
      if (rsp_valid) begin
        if (hold) begin
          check("hold_id", rsp_id, hid);
          check("hold_result", rsp_result, hres);
          check("hold_zero", rsp_zero, hz);
        end
        if (rsp_ready) begin
          check("sb_nonempty", sbq.size() != 0, 1);
          if (sbq.size() != 0) begin
            e = sbq.pop_front();
            check("rsp_id", rsp_id, e.id);
            check("rsp_result", rsp_result, e.res);
            check("rsp_zero", rsp_zero, e.z);
            mptr = ~e.id;
          end
          outst = 0;
          hold  = 0;
        end else begin
          hold = 1;
          hid  = rsp_id;
          hres = rsp_result;
          hz   = rsp_zero;
        end
      end else begin
        hold = 0;
      end
      eg = 2'b00;
      gi = req_valid[mptr] ? mptr : ~mptr;
      if (!o && req_valid != 2'b00) eg[gi] = 1'b1;
      check("req_ready", req_ready, eg);
      if (eg != 2'b00) begin
        e.id  = gi;
        e.res = alu_ref(r_aluop[gi], r_fun3[gi], r_fun7[gi], r_a[gi], r_b[gi]);
        e.z   = (e.res == '0);
        sbq.push_back(e);
        outst   = 1;
        acc_cyc = cyc;
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [1:0] op, input logic [2:0] f3, input logic f7,
                         input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    r_aluop[i] = op; r_fun3[i] = f3; r_fun7[i] = f7; r_a[i] = a; r_b[i] = b;
  endtask

  task automatic rand_req(input int i);
    logic [XLEN-1:0] a;
    a = ($urandom % 3 == 0) ? XLEN'($urandom % 16) : XLEN'($urandom);
    set_req(i, 2'($urandom % 4), 3'($urandom), 1'($urandom),
            a, ($urandom % 4 == 0) ? a : XLEN'($urandom));
  endtask

  // Waits for requester i to be accepted, then drops its valid in the EXEC cycle.
  task automatic wait_accept(input int i);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req_ready[i]) begin
        cycle();
        req_valid[i] = 1'b0;
        return;
      end
    end
    fail_now("accept_timeout");
  endtask

  task automatic wait_rsp_valid();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rsp_valid) return;
    end
    fail_now("rsp_valid_timeout");
  endtask

  // Returns at the negedge of the handshake cycle.
  task automatic wait_rsp(input logic id, input logic [XLEN-1:0] res, input logic z);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) begin
        check("dir_rsp_id", rsp_id, id);
        check("dir_rsp_result", rsp_result, res);
        check("dir_rsp_zero", rsp_zero, z);
        return;
      end
    end
    fail_now("rsp_timeout");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] acc;
    for (int i = 0; i < 2; i++) set_req(i, 2'b00, 3'b000, 1'b0, '0, '0);

    // Reset values
    #1 rst_n = 1'b0;
    #1;
    check("rst_req_ready", req_ready, 2'b00);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_rsp_result", rsp_result, 0);
    check("rst_rsp_zero", rsp_zero, 0);
    check("rst_alu_fields", {alu_aluop, alu_fun3, alu_fun7}, 0);
    check("rst_alu_ab", {alu_a, alu_b}, 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    cycle();

    // Single add from requester 0
    rsp_ready = 1'b1;
    set_req(0, ALUOP_ADD, 3'b000, 1'b0, 32'd5, 32'd7);
    req_valid = 2'b01;
    @(negedge clk);
    check("add_req_ready", req_ready, 2'b01);
    cycle();
    req_valid = 2'b00;
    wait_rsp(1'b0, 32'd12, 1'b0);
    cycle();

    // Sub to zero from requester 1
    set_req(1, ALUOP_SUB, 3'b000, 1'b0, 32'h1234, 32'h1234);
    req_valid = 2'b10;
    wait_accept(1);
    wait_rsp(1'b1, 32'd0, 1'b1);
    cycle();

    // Contention: add on 0, R-type AND on 1, both valid continuously
    set_req(0, ALUOP_ADD, 3'b000, 1'b0, 32'hF0, 32'h3C);
    set_req(1, ALUOP_RTYPE, 3'b111, 1'b0, 32'hF0, 32'h3C);
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_rsp(1'(k % 2), (k % 2) ? 32'h30 : 32'h12C, 1'b0);
    end
    cycle();
    req_valid = 2'b00;

    // Backpressure with both requesters waiting
    rsp_ready = 1'b0;
    req_valid = 2'b11;
    wait_rsp_valid();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_req_ready", req_ready, 2'b00);
      check("bp_rsp_valid", rsp_valid, 1);
      check("bp_rsp_result", rsp_result, 32'h12C);
    end
    cycle();
    rsp_ready = 1'b1;
    wait_rsp(1'b0, 32'h12C, 1'b0);
    @(negedge clk);
    check("bp_resume", req_ready, 2'b10);
    cycle();
    req_valid = 2'b00;
    wait_rsp(1'b1, 32'h30, 1'b0);
    cycle();

    // Withdrawn request during EXEC
    set_req(0, ALUOP_ADD, 3'b000, 1'b0, 32'd100, 32'd23);
    req_valid = 2'b01;
    wait_accept(0);
    req_valid = 2'b10;
    cycle();
    req_valid = 2'b00;
    wait_rsp(1'b0, 32'd123, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("wd_req_ready", req_ready, 2'b00);
      check("wd_busy", busy, 0);
    end
    cycle();

    // Reset mid-RESP with pointer at 1
    rsp_ready = 1'b0;
    set_req(1, ALUOP_SUB, 3'b000, 1'b0, 32'd50, 32'd8);
    req_valid = 2'b10;
    wait_accept(1);
    wait_rsp_valid();
    cycle();
    set_req(0, ALUOP_ADD, 3'b000, 1'b0, 32'd3, 32'd4);
    set_req(1, ALUOP_ADD, 3'b000, 1'b0, 32'd10, 32'd20);
    req_valid = 2'b11;
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_rsp_valid", rsp_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_req_ready", req_ready, 2'b00);
    check("mid_rst_rsp_result", rsp_result, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_grant", req_ready, 2'b01);
    cycle();
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    wait_rsp(1'b0, 32'd7, 1'b0);
    cycle();

    // Randomized traffic against the scoreboard
    for (int it = 0; it < 600; it++) begin
      @(negedge clk);
      acc = req_ready & req_valid;
      cycle();
      for (int i = 0; i < 2; i++) begin
        if (acc[i] || !req_valid[i]) begin
          if ($urandom % 2 == 0) begin
            rand_req(i);
            req_valid[i] = 1'b1;
          end else begin
            req_valid[i] = 1'b0;
          end
        end else if ($urandom % 10 == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      rsp_ready = ($urandom % 10) < 7;
    end
    cycle();
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    repeat (6) cycle();
    @(negedge clk);
    check("drain_sb_empty", sbq.size(), 0);
    check("drain_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
